branch_predictor: RTL and testbench
===================================

# branch_predictor

Parametrised branch target buffer with per-entry saturating direction counters for the pipelined RISC-V core. The fetch stage looks up the current PC combinationally and gets a predicted next PC. The decode stage, where branches and jumps resolve, writes the resolved outcome back. The block flags mispredictions, supplies the redirect PC for the IF flush, and keeps branch and mispredict statistics.

## Interface
- DATA_W, 64, PC and target width
- ENTRIES, 16, table depth; power of two, at least 2; IDX_W = log2(ENTRIES)
- CTR_W, 2, direction counter width, at least 1
- CNT_W, 32, statistics counter width
- clk  input  1  main clock
- arst_n  input  1  reset; asynchronous, active-low
- enable  input  1  global run enable; no state change when low
- clear  input  1  synchronous invalidate of all entries and statistics
- lookup_pc  input  DATA_W  PC of the instruction being fetched
- hit  output  1  valid entry with matching tag
- pred_taken  output  1  hit and counter MSB set
- pred_next_pc  output  DATA_W  stored target if pred_taken, else lookup_pc+4
- upd_valid  input  1  resolved branch or jump present in decode
- upd_pc  input  DATA_W  PC of the resolved instruction
- upd_taken  input  1  resolved direction
- upd_target  input  DATA_W  resolved target
- upd_pred_taken  input  1  pred_taken that travelled down the pipe with this instruction
- upd_pred_target  input  DATA_W  pred_next_pc that travelled down the pipe with this instruction
- mispredict  output  1  redirect required
- redirect_pc  output  DATA_W  upd_taken ? upd_target : upd_pc+4
- branch_cnt  output  CNT_W  number of updates accepted
- mispredict_cnt  output  CNT_W  number of mispredicts

## Operation
- Index and tag:
  - PCs are word aligned; bits [1:0] are ignored.
  - Index = pc[IDX_W+1:2].
  - Tag = pc[DATA_W-1:IDX_W+2].
- Entry contents: valid, tag, target, CTR_W-bit counter.
- Lookup is purely combinational. There is no bypass from an update in the same cycle; lookup reads pre-edge state.
- Mispredict is combinational:
  - mispredict = upd_valid && (upd_taken != upd_pred_taken || (upd_taken && upd_target != upd_pred_target)).
  - mispredict is evaluated regardless of enable.
- Update is applied at the clock edge when enable && upd_valid && !clear:
  - Hit on upd_pc, taken: counter increments, saturating at 2^CTR_W-1; target is overwritten with upd_target.
  - Hit, not taken: counter decrements, saturating at 0; target is unchanged.
  - Miss, taken: the entry at the index is allocated or replaced. valid=1, tag written, target=upd_target, counter = 2^(CTR_W-1) (weakly taken).
  - Miss, not taken: no allocation.
- Statistics, at the same edge as the update:
  - branch_cnt increments by 1.
  - mispredict_cnt increments by 1 if mispredict.
  - Both saturate at 2^CNT_W-1.
- clear with enable high:
  - All valid bits go to 0 and both statistics counters go to 0 at the edge.
  - clear takes priority over a simultaneous update, which is dropped and not counted.
  - Targets, tags and counters are left as they are.
- Reset:
  - All valid bits, counters, tags, targets and statistics go to 0.
  - Output values under reset: hit=0, pred_taken=0, pred_next_pc=lookup_pc+4, branch_cnt=0, mispredict_cnt=0. mispredict and redirect_pc follow their inputs.
- Arithmetic: the +4 adders are DATA_W wide, unsigned, and wrap modulo 2^DATA_W (0xFFFF_FFFF_FFFF_FFFC+4 = 0).

## Timing
- Lookup outputs have zero cycles of latency from lookup_pc.
- mispredict and redirect_pc have zero cycles of latency from the upd_* inputs.
- An update at edge N is visible to lookup from cycle N+1 onward.
- Only one update per cycle. No backpressure; upd_valid is a single-cycle strobe per resolved instruction.
- Asserting arst_n low mid-operation clears state immediately, without waiting for a clock. The first update is accepted on the first edge after release.

## Structure
- Shared package bp_pkg holds:
  - the weak-taken init constant
  - the IDX_W and TAG_W derivation functions
  - the PC increment constant 4
- One sub-module, sat_counter: a CTR_W-bit up/down saturating counter with inc/dec enables, instantiated per entry. The statistics counters use a separate CNT_W-wide saturating-increment instance.
- The table is flip-flop based, with no SRAM macro, so lookup can be combinational.

## Test plan
All scenarios use the default parameters.
- Reset, lookup_pc=0x40 -> hit=0, pred_taken=0, pred_next_pc=0x44, both counters 0.
- Update 0x40 taken, target 0x100, pred_taken=0 -> mispredict=1, redirect_pc=0x100, mispredict_cnt=1. Next cycle, lookup 0x40 -> hit=1, pred_taken=1, pred_next_pc=0x100.
- Counter saturation:
  - Three more taken updates on 0x40 -> counter=3.
  - One not-taken update -> still predicts taken.
  - Second not-taken update -> pred_taken=0, pred_next_pc=0x44.
- Alias (0x40 and 0x440 share index 0):
  - Lookup 0x440 -> hit=0.
  - Taken update 0x440, target 0x200 -> lookup 0x440 gives pred_next_pc=0x200, and lookup 0x40 now misses.
- Control priority:
  - clear and a taken upd_valid in the same cycle -> all entries invalid, both statistics counters 0, update not allocated.
  - upd_valid with enable=0 -> no state change, but mispredict is still driven.
- Async reset pulsed between edges with entries valid -> hit drops to 0 before the next clk edge.
- Wrap: lookup_pc=0xFFFF_FFFF_FFFF_FFFC on a miss -> pred_next_pc=0.

Source files
------------

// File: rtl/bp_pkg.sv
// rtl/bp_pkg.sv - shared constants and width helpers for the branch predictor
package bp_pkg;

  localparam int PC_INC = 4;

  function automatic int idx_w(input int entries);
    return $clog2(entries);
  endfunction

  function automatic int tag_w(input int data_w, input int entries);
    return data_w - $clog2(entries) - 2;
  endfunction

  // Counter value a freshly allocated entry starts at: MSB set, rest clear.
  function automatic int weak_taken_init(input int ctr_w);
    return 1 << (ctr_w - 1);
  endfunction

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - W-bit up/down saturating counter with sync clear and load
module sat_counter #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         arst_n,
  input  logic         clr,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         inc,
  input  logic         dec,
  output logic [W-1:0] q
);

  localparam logic [W-1:0] MAX = '1;

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else if (load) begin
      q <= load_val;
    end else if (inc && !dec && q != MAX) begin
      q <= q + W'(1);
    end else if (dec && !inc && q != '0) begin
      q <= q - W'(1);
    end
  end

endmodule

// File: rtl/branch_predictor.sv
// rtl/branch_predictor.sv - flop-based BTB with per-entry direction counters,
// mispredict detection and branch/mispredict statistics
module branch_predictor
  import bp_pkg::*;
#(
  parameter int DATA_W  = 64,
  parameter int ENTRIES = 16,
  parameter int CTR_W   = 2,
  parameter int CNT_W   = 32
) (
  input  logic              clk,
  input  logic              arst_n,
  input  logic              enable,
  input  logic              clear,
  input  logic [DATA_W-1:0] lookup_pc,
  output logic              hit,
  output logic              pred_taken,
  output logic [DATA_W-1:0] pred_next_pc,
  input  logic              upd_valid,
  input  logic [DATA_W-1:0] upd_pc,
  input  logic              upd_taken,
  input  logic [DATA_W-1:0] upd_target,
  input  logic              upd_pred_taken,
  input  logic [DATA_W-1:0] upd_pred_target,
  output logic              mispredict,
  output logic [DATA_W-1:0] redirect_pc,
  output logic [CNT_W-1:0]  branch_cnt,
  output logic [CNT_W-1:0]  mispredict_cnt
);

  localparam int IDX_W = idx_w(ENTRIES);
  localparam int TAG_W = tag_w(DATA_W, ENTRIES);
  localparam logic [CTR_W-1:0] CTR_INIT = CTR_W'(weak_taken_init(CTR_W));
  localparam logic [DATA_W-1:0] INC = DATA_W'(PC_INC);

  logic [ENTRIES-1:0] valid_q;
  logic [TAG_W-1:0]   tag_q    [ENTRIES];
  logic [DATA_W-1:0]  target_q [ENTRIES];
  logic [CTR_W-1:0]   ctr_q    [ENTRIES];

  logic [IDX_W-1:0] l_idx, u_idx;
  logic [TAG_W-1:0] l_tag, u_tag;
  logic             u_hit;
  logic             accept;
  logic             clr_all;

  assign l_idx = lookup_pc[IDX_W+1:2];
  assign l_tag = lookup_pc[DATA_W-1:IDX_W+2];
  assign u_idx = upd_pc[IDX_W+1:2];
  assign u_tag = upd_pc[DATA_W-1:IDX_W+2];

  // Lookup reads the pre-edge table; an update in the same cycle is not bypassed.
  assign hit          = valid_q[l_idx] && (tag_q[l_idx] == l_tag);
  assign pred_taken   = hit && ctr_q[l_idx][CTR_W-1];
  assign pred_next_pc = pred_taken ? target_q[l_idx] : lookup_pc + INC;

  assign mispredict  = upd_valid &&
                       ((upd_taken != upd_pred_taken) ||
                        (upd_taken && (upd_target != upd_pred_target)));
  assign redirect_pc = upd_taken ? upd_target : upd_pc + INC;

  assign u_hit   = valid_q[u_idx] && (tag_q[u_idx] == u_tag);
  assign clr_all = enable && clear;
  assign accept  = enable && upd_valid && !clear;

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      valid_q <= '0;
      for (int i = 0; i < ENTRIES; i++) begin
        tag_q[i]    <= '0;
        target_q[i] <= '0;
      end
    end else if (clr_all) begin
      valid_q <= '0;
    end else if (accept && upd_taken) begin
      // Taken either refreshes the target on a hit or (re)allocates on a miss.
      target_q[u_idx] <= upd_target;
      if (!u_hit) begin
        valid_q[u_idx] <= 1'b1;
        tag_q[u_idx]   <= u_tag;
      end
    end
  end

  for (genvar i = 0; i < ENTRIES; i++) begin : g_entry
    logic sel;
    assign sel = (u_idx == IDX_W'(i));

    sat_counter #(.W(CTR_W)) u_dir (
      .clk      (clk),
      .arst_n   (arst_n),
      .clr      (1'b0),
      .load     (accept && sel && !u_hit && upd_taken),
      .load_val (CTR_INIT),
      .inc      (accept && sel && u_hit && upd_taken),
      .dec      (accept && sel && u_hit && !upd_taken),
      .q        (ctr_q[i])
    );
  end

  sat_counter #(.W(CNT_W)) u_branch_cnt (
    .clk      (clk),
    .arst_n   (arst_n),
    .clr      (clr_all),
    .load     (1'b0),
    .load_val ('0),
    .inc      (accept),
    .dec      (1'b0),
    .q        (branch_cnt)
  );

  sat_counter #(.W(CNT_W)) u_mispredict_cnt (
    .clk      (clk),
    .arst_n   (arst_n),
    .clr      (clr_all),
    .load     (1'b0),
    .load_val ('0),
    .inc      (accept && mispredict),
    .dec      (1'b0),
    .q        (mispredict_cnt)
  );

endmodule

// File: tb/tb_branch_predictor.sv
// tb/tb_branch_predictor.sv - scoreboard bench for branch_predictor
module tb_branch_predictor;

  logic        clk = 1'b0;
  logic        arst_n;
  logic        enable;
  logic        clear;
  logic [63:0] lookup_pc;
  logic        hit;
  logic        pred_taken;
  logic [63:0] pred_next_pc;
  logic        upd_valid;
  logic [63:0] upd_pc;
  logic        upd_taken;
  logic [63:0] upd_target;
  logic        upd_pred_taken;
  logic [63:0] upd_pred_target;
  logic        mispredict;
  logic [63:0] redirect_pc;
  logic [31:0] branch_cnt;
  logic [31:0] mispredict_cnt;

  branch_predictor dut (
    .clk             (clk),
    .arst_n          (arst_n),
    .enable          (enable),
    .clear           (clear),
    .lookup_pc       (lookup_pc),
    .hit             (hit),
    .pred_taken      (pred_taken),
    .pred_next_pc    (pred_next_pc),
    .upd_valid       (upd_valid),
    .upd_pc          (upd_pc),
    .upd_taken       (upd_taken),
    .upd_target      (upd_target),
    .upd_pred_taken  (upd_pred_taken),
    .upd_pred_target (upd_pred_target),
    .mispredict      (mispredict),
    .redirect_pc     (redirect_pc),
    .branch_cnt      (branch_cnt),
    .mispredict_cnt  (mispredict_cnt)
  );

  always #5 clk = ~clk;

  typedef enum int {F_HIT, F_PT, F_NPC, F_MIS, F_RPC, F_BC, F_MC} field_t;
  typedef struct {
    string       nm;
    field_t      f;
    logic [63:0] v;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic expect_val(input string nm, input field_t f, input logic [63:0] v);
    exp_t e;
    e.nm = nm;
    e.f  = f;
    e.v  = v;
    exp_q.push_back(e);
  endtask

  function automatic logic [63:0] actual(input field_t f);
    case (f)
      F_HIT:   return {63'd0, hit};
      F_PT:    return {63'd0, pred_taken};
      F_NPC:   return pred_next_pc;
      F_MIS:   return {63'd0, mispredict};
      F_RPC:   return redirect_pc;
      F_BC:    return {32'd0, branch_cnt};
      default: return {32'd0, mispredict_cnt};
    endcase
  endfunction

  // Monitor: drains every expectation queued during the current cycle.
  initial begin
    forever begin
      @(negedge clk);
      while (exp_q.size() > 0) begin
        exp_t e;
        logic [63:0] a;
        e = exp_q.pop_front();
        a = actual(e.f);
        checks++;
        if (a !== e.v) begin
          errors++;
          $display("FAIL %s: got 0x%0h expected 0x%0h", e.nm, a, e.v);
        end
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    upd_valid       = 1'b0;
    upd_pc          = '0;
    upd_taken       = 1'b0;
    upd_target      = '0;
    upd_pred_taken  = 1'b0;
    upd_pred_target = '0;
  endtask

  task automatic upd(input logic [63:0] pc, input logic tk, input logic [63:0] tgt,
                     input logic ptk, input logic [63:0] ptgt);
    upd_valid       = 1'b1;
    upd_pc          = pc;
    upd_taken       = tk;
    upd_target      = tgt;
    upd_pred_taken  = ptk;
    upd_pred_target = ptgt;
  endtask

  initial begin
    arst_n    = 1'b0;
    enable    = 1'b1;
    clear     = 1'b0;
    lookup_pc = 64'h40;
    idle();

    cyc();
    expect_val("reset_hit", F_HIT, 0);
    expect_val("reset_pt", F_PT, 0);
    expect_val("reset_npc", F_NPC, 64'h44);
    expect_val("reset_bc", F_BC, 0);
    expect_val("reset_mc", F_MC, 0);
    cyc();
    arst_n = 1'b1;

    cyc();
    upd(64'h40, 1, 64'h100, 0, 64'h44);
    expect_val("first_mis", F_MIS, 1);
    expect_val("first_rpc", F_RPC, 64'h100);
    expect_val("first_no_bypass", F_HIT, 0);
    cyc();
    idle();
    expect_val("alloc_hit", F_HIT, 1);
    expect_val("alloc_pt", F_PT, 1);
    expect_val("alloc_npc", F_NPC, 64'h100);
    expect_val("alloc_bc", F_BC, 1);
    expect_val("alloc_mc", F_MC, 1);

    for (int i = 0; i < 3; i++) begin
      cyc();
      upd(64'h40, 1, 64'h100, 1, 64'h100);
      expect_val("taken_nomis", F_MIS, 0);
    end
    cyc();
    idle();
    expect_val("sat_pt", F_PT, 1);
    expect_val("sat_bc", F_BC, 4);
    expect_val("sat_mc", F_MC, 1);

    cyc();
    upd(64'h40, 0, 64'h100, 1, 64'h100);
    expect_val("nt1_mis", F_MIS, 1);
    expect_val("nt1_rpc", F_RPC, 64'h44);
    cyc();
    idle();
    expect_val("nt1_still_taken", F_PT, 1);
    expect_val("nt1_npc", F_NPC, 64'h100);
    cyc();
    upd(64'h40, 0, 64'h100, 1, 64'h100);
    expect_val("nt2_mis", F_MIS, 1);
    cyc();
    idle();
    expect_val("nt2_hit", F_HIT, 1);
    expect_val("nt2_pt", F_PT, 0);
    expect_val("nt2_npc", F_NPC, 64'h44);
    expect_val("nt2_bc", F_BC, 6);
    expect_val("nt2_mc", F_MC, 3);

    cyc();
    lookup_pc = 64'h440;
    expect_val("alias_miss", F_HIT, 0);
    expect_val("alias_npc", F_NPC, 64'h444);
    cyc();
    upd(64'h440, 1, 64'h200, 0, 64'h444);
    expect_val("alias_mis", F_MIS, 1);
    expect_val("alias_rpc", F_RPC, 64'h200);
    cyc();
    idle();
    expect_val("alias_hit", F_HIT, 1);
    expect_val("alias_npc2", F_NPC, 64'h200);
    expect_val("alias_bc", F_BC, 7);
    expect_val("alias_mc", F_MC, 4);
    cyc();
    lookup_pc = 64'h40;
    expect_val("evicted_hit", F_HIT, 0);
    expect_val("evicted_npc", F_NPC, 64'h44);

    cyc();
    lookup_pc = 64'h440;
    upd(64'h440, 1, 64'h280, 1, 64'h200);
    expect_val("retarget_mis", F_MIS, 1);
    expect_val("retarget_rpc", F_RPC, 64'h280);
    expect_val("retarget_prior_npc", F_NPC, 64'h200);
    cyc();
    idle();
    expect_val("retarget_npc", F_NPC, 64'h280);
    expect_val("retarget_bc", F_BC, 8);
    expect_val("retarget_mc", F_MC, 5);

    cyc();
    lookup_pc = 64'h84;
    upd(64'h84, 1, 64'h300, 0, 64'h88);
    expect_val("idx1_prior_hit", F_HIT, 0);
    cyc();
    idle();
    expect_val("idx1_hit", F_HIT, 1);
    expect_val("idx1_npc", F_NPC, 64'h300);
    expect_val("idx1_bc", F_BC, 9);
    expect_val("idx1_mc", F_MC, 6);

    cyc();
    clear = 1'b1;
    upd(64'h500, 1, 64'h600, 0, 64'h504);
    expect_val("clear_mis", F_MIS, 1);
    cyc();
    clear = 1'b0;
    idle();
    lookup_pc = 64'h500;
    expect_val("clear_no_alloc", F_HIT, 0);
    expect_val("clear_bc", F_BC, 0);
    expect_val("clear_mc", F_MC, 0);
    cyc();
    lookup_pc = 64'h84;
    expect_val("clear_idx1", F_HIT, 0);
    cyc();
    lookup_pc = 64'h440;
    expect_val("clear_idx0", F_HIT, 0);

    cyc();
    enable    = 1'b0;
    lookup_pc = 64'h40;
    upd(64'h40, 1, 64'h100, 0, 64'h44);
    expect_val("dis_mis", F_MIS, 1);
    expect_val("dis_rpc", F_RPC, 64'h100);
    cyc();
    enable = 1'b1;
    idle();
    expect_val("dis_no_alloc", F_HIT, 0);
    expect_val("dis_bc", F_BC, 0);
    expect_val("dis_mc", F_MC, 0);

    cyc();
    lookup_pc = 64'h84;
    upd(64'h84, 1, 64'h300, 0, 64'h88);
    cyc();
    idle();
    expect_val("pre_rst_hit", F_HIT, 1);
    expect_val("pre_rst_npc", F_NPC, 64'h300);
    expect_val("pre_rst_bc", F_BC, 1);
    cyc();
    arst_n = 1'b0;
    #2;
    arst_n = 1'b1;
    expect_val("arst_hit", F_HIT, 0);
    expect_val("arst_npc", F_NPC, 64'h88);
    expect_val("arst_bc", F_BC, 0);
    expect_val("arst_mc", F_MC, 0);

    cyc();
    enable    = 1'b0;
    lookup_pc = 64'hFFFF_FFFF_FFFF_FFFC;
    upd(64'hFFFF_FFFF_FFFF_FFFC, 0, 64'h0, 0, 64'h0);
    expect_val("wrap_hit", F_HIT, 0);
    expect_val("wrap_npc", F_NPC, 64'h0);
    expect_val("wrap_mis", F_MIS, 0);
    expect_val("wrap_rpc", F_RPC, 64'h0);

    cyc();
    enable = 1'b1;
    idle();
    @(negedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
